// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, FSM state type and tag-set type for the set-associative cache controller.
package cache_pkg;
   localparam int TAG_W = 36;
   localparam int WAYS = 4;
   localparam int SETS_DEF = 64;
   localparam int OFF_W_DEF = 6;
   typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, STORE, FLUSH} state_t;
   typedef logic [WAYS-1:0][TAG_W-1:0] tag_set_t;
endpackage

// File: rtl/cache_controller_if.sv
// cache_controller_if: CPU, hit/miss comparator, data array and memory port signals of the cache controller.
interface cache_controller_if #(parameter int SETS = cache_pkg::SETS_DEF, parameter int OFF_W = cache_pkg::OFF_W_DEF);
   localparam int INDEX_W = $clog2(SETS);
   localparam int ADDR_W = cache_pkg::TAG_W + INDEX_W + OFF_W;
   logic cpu_req, cpu_we, cpu_ready, cpu_done, flush;
   logic [ADDR_W-1:0] cpu_addr;
   logic [cache_pkg::TAG_W-1:0] hm_tag_addr;
   cache_pkg::tag_set_t hm_tag;
   logic [3:0] hm_valid, hm_way_hit;
   logic hm_hit;
   logic da_we, da_fill;
   logic [1:0] da_way;
   logic [INDEX_W-1:0] da_index;
   logic mem_req, mem_we, mem_ack;
   logic [ADDR_W-1:0] mem_addr;
   modport master (
      output cpu_req, cpu_we, cpu_addr, flush, hm_way_hit, hm_hit, mem_ack,
      input cpu_ready, cpu_done, hm_tag_addr, hm_tag, hm_valid, da_we, da_fill, da_way, da_index, mem_req, mem_we, mem_addr
   );
   modport slave (
      input cpu_req, cpu_we, cpu_addr, flush, hm_way_hit, hm_hit, mem_ack,
      output cpu_ready, cpu_done, hm_tag_addr, hm_tag, hm_valid, da_we, da_fill, da_way, da_index, mem_req, mem_we, mem_addr
   );
endinterface

// File: rtl/cache_replace.sv
// cache_replace: per-set round-robin pointers and invalid-first victim selection.
module cache_replace #(parameter int SETS = 64) (
   input logic clk,
   input logic rst_n,
   input logic [3:0] valid,
   input logic [$clog2(SETS)-1:0] index,
   input logic advance,
   output logic [1:0] victim
);
   logic [SETS-1:0][1:0] ptr;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr <= '0;
      else if (advance) ptr[index] <= ptr[index] + 2'd1;
   end
   assign victim = !valid[0] ? 2'd0 : !valid[1] ? 2'd1 : !valid[2] ? 2'd2 : !valid[3] ? 2'd3 : ptr[index];
endmodule

// File: rtl/cache_controller.sv
// cache_controller: tag/valid storage and sequencing FSM for a 4-way write-through,
// no-write-allocate cache: lookup, line refill, store-through and full flush.
module cache_controller import cache_pkg::*; #(
   parameter int SETS = SETS_DEF,
   parameter int OFF_W = OFF_W_DEF
) (
   input logic clk,
   input logic rst_n,
   cache_controller_if.slave bus
);
   localparam int INDEX_W = $clog2(SETS);
   localparam int ADDR_W = TAG_W + INDEX_W + OFF_W;
   state_t state, next;
   logic req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [SETS-1:0][WAYS-1:0] valid;
   tag_set_t tags [SETS];
   logic [INDEX_W-1:0] fcnt, idx;
   logic [TAG_W-1:0] tag;
   logic [1:0] hit_way, victim;
   logic fill;
   assign idx = req_addr[OFF_W +: INDEX_W];
   assign tag = req_addr[ADDR_W-1 -: TAG_W];
   assign fill = state == REFILL && bus.mem_ack;
   assign hit_way = bus.hm_way_hit[0] ? 2'd0 : bus.hm_way_hit[1] ? 2'd1 : bus.hm_way_hit[2] ? 2'd2 : 2'd3;
   assign bus.hm_tag_addr = tag;
   assign bus.hm_tag = tags[idx];
   assign bus.hm_valid = valid[idx];
   assign bus.da_index = idx;
   // the pointer only moves when it actually chose the victim, i.e. the set was full
   cache_replace #(.SETS(SETS)) u_replace (
      .clk(clk), .rst_n(rst_n), .valid(valid[idx]), .index(idx),
      .advance(fill && &valid[idx]), .victim(victim)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         req_we <= 1'b0;
         req_addr <= '0;
         valid <= '0;
         fcnt <= '0;
      end else begin
         state <= next;
         if (state == IDLE && !bus.flush && bus.cpu_req) begin
            req_we <= bus.cpu_we;
            req_addr <= bus.cpu_addr;
         end
         if (fill) valid[idx][victim] <= 1'b1;
         if (state == FLUSH) begin
            valid[fcnt] <= '0;
            fcnt <= fcnt + 1'b1;
         end
      end
   end
   always_ff @(posedge clk) if (fill) tags[idx][victim] <= tag;
   always_comb begin
      next = state;
      bus.cpu_ready = 1'b0;
      bus.cpu_done = 1'b0;
      bus.da_we = 1'b0;
      bus.da_fill = 1'b0;
      bus.da_way = 2'd0;
      bus.mem_req = 1'b0;
      bus.mem_we = 1'b0;
      bus.mem_addr = '0;
      case (state)
         IDLE: begin
            bus.cpu_ready = 1'b1;
            next = bus.flush ? FLUSH : bus.cpu_req ? LOOKUP : IDLE;
         end
         LOOKUP: begin
            bus.da_way = hit_way;
            bus.da_we = req_we && bus.hm_hit;
            bus.cpu_done = !req_we && bus.hm_hit;
            next = req_we ? STORE : bus.hm_hit ? IDLE : REFILL;
         end
         REFILL: begin
            bus.mem_req = 1'b1;
            bus.mem_addr = {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            bus.da_we = bus.mem_ack;
            bus.da_fill = bus.mem_ack;
            bus.da_way = bus.mem_ack ? victim : 2'd0;
            bus.cpu_done = bus.mem_ack;
            next = bus.mem_ack ? IDLE : REFILL;
         end
         STORE: begin
            bus.mem_req = 1'b1;
            bus.mem_we = 1'b1;
            bus.mem_addr = req_addr;
            bus.cpu_done = bus.mem_ack;
            next = bus.mem_ack ? IDLE : STORE;
         end
         FLUSH: begin
            bus.cpu_done = fcnt == INDEX_W'(SETS - 1);
            next = bus.cpu_done ? IDLE : FLUSH;
         end
         default: next = IDLE;
      endcase
   end
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed scenarios with hand-computed expectations; the bench plays the comparator path.
module tb_cache_controller;
   logic clk = 1'b0, rst_n = 1'b0;
   int checks = 0, errors = 0;
   cache_controller_if bus();
   cache_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   always_comb begin
      for (int w = 0; w < 4; w++) bus.hm_way_hit[w] = bus.hm_valid[w] && bus.hm_tag[w] == bus.hm_tag_addr;
      bus.hm_hit = |bus.hm_way_hit;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   task automatic load(input logic [47:0] a, input bit miss, input logic [1:0] way, input string nm);
      bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = a; #1;
      checks++;
      if (bus.cpu_ready !== 1'b1) begin errors++; $display("FAIL %s ready: got %b want 1", nm, bus.cpu_ready); end
      @(negedge clk); bus.cpu_req = 0; #1;
      checks++;
      if ({bus.cpu_done, bus.mem_req} !== {!miss, 1'b0} || (!miss && bus.da_way !== way)) begin
         errors++; $display("FAIL %s lookup: done=%b mem_req=%b way=%0d want done=%b way=%0d", nm, bus.cpu_done, bus.mem_req, bus.da_way, !miss, way);
      end
      if (miss) begin
         @(negedge clk); #1;
         checks++;
         if ({bus.mem_req, bus.mem_we, bus.cpu_done} !== 3'b100 || bus.mem_addr !== {a[47:6], 6'b0}) begin
            errors++; $display("FAIL %s refill req: req=%b we=%b done=%b addr=%h want 1 0 0 %h", nm, bus.mem_req, bus.mem_we, bus.cpu_done, bus.mem_addr, {a[47:6], 6'b0});
         end
         bus.mem_ack = 1; #1;
         checks++;
         if ({bus.da_we, bus.da_fill, bus.da_way, bus.cpu_done} !== {2'b11, way, 1'b1}) begin
            errors++; $display("FAIL %s refill ack: we=%b fill=%b way=%0d done=%b want 1 1 %0d 1", nm, bus.da_we, bus.da_fill, bus.da_way, bus.cpu_done, way);
         end
      end
      @(negedge clk); bus.mem_ack = 0;
   endtask
   task automatic test_reset();
      #1;
      checks++;
      if ({bus.cpu_ready, bus.cpu_done, bus.da_we, bus.da_fill, bus.mem_req, bus.mem_we} !== 6'b100000 || bus.mem_addr !== '0 || bus.da_way !== 2'd0 || bus.da_index !== 6'd0 || bus.hm_valid !== 4'd0) begin
         errors++; $display("FAIL reset: ready=%b done=%b da_we=%b fill=%b req=%b we=%b addr=%h way=%0d idx=%0d valid=%b", bus.cpu_ready, bus.cpu_done, bus.da_we, bus.da_fill, bus.mem_req, bus.mem_we, bus.mem_addr, bus.da_way, bus.da_index, bus.hm_valid);
      end
      @(negedge clk);
   endtask
   task automatic test_miss_hit();
      load(48'h1040, 1, 2'd0, "first_miss");
      checks++;
      if (bus.da_index !== 6'd1) begin errors++; $display("FAIL index: got %0d want 1", bus.da_index); end
      load(48'h1047, 0, 2'd0, "repeat_hit");
   endtask
   task automatic test_replacement();
      load(48'h2040, 1, 2'd1, "fill_w1");
      load(48'h3040, 1, 2'd2, "fill_w2");
      load(48'h4040, 1, 2'd3, "fill_w3");
      load(48'h5040, 1, 2'd0, "rr_evict_w0");
      load(48'h6040, 1, 2'd1, "rr_evict_w1");
      load(48'h1040, 1, 2'd2, "evicted_reload");
      load(48'h5048, 0, 2'd0, "rr_hit_w0");
   endtask
   task automatic test_store();
      bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 48'h4050;
      @(negedge clk); bus.cpu_req = 0; #1;
      checks++;
      if ({bus.da_we, bus.da_fill, bus.da_way, bus.cpu_done, bus.mem_req} !== 6'b10_11_00) begin
         errors++; $display("FAIL store_hit lookup: we=%b fill=%b way=%0d done=%b req=%b want 1 0 3 0 0", bus.da_we, bus.da_fill, bus.da_way, bus.cpu_done, bus.mem_req);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         checks++;
         if ({bus.mem_req, bus.mem_we, bus.cpu_done, bus.da_we} !== 4'b1100 || bus.mem_addr !== 48'h4050) begin
            errors++; $display("FAIL store_hit write cyc%0d: req=%b we=%b done=%b addr=%h want 1 1 0 4050", i, bus.mem_req, bus.mem_we, bus.cpu_done, bus.mem_addr);
         end
      end
      bus.mem_ack = 1; #1;
      checks++;
      if ({bus.cpu_done, bus.da_we} !== 2'b10) begin errors++; $display("FAIL store_hit ack: done=%b da_we=%b want 1 0", bus.cpu_done, bus.da_we); end
      @(negedge clk); bus.mem_ack = 0;
      bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 48'h9044;
      @(negedge clk); bus.cpu_req = 0; #1;
      checks++;
      if ({bus.da_we, bus.cpu_done} !== 2'b00) begin errors++; $display("FAIL store_miss lookup: da_we=%b done=%b want 0 0", bus.da_we, bus.cpu_done); end
      @(negedge clk); #1;
      checks++;
      if ({bus.mem_req, bus.mem_we} !== 2'b11 || bus.mem_addr !== 48'h9044) begin
         errors++; $display("FAIL store_miss write: req=%b we=%b addr=%h want 1 1 9044", bus.mem_req, bus.mem_we, bus.mem_addr);
      end
      bus.mem_ack = 1; #1;
      checks++;
      if ({bus.cpu_done, bus.da_we} !== 2'b10) begin errors++; $display("FAIL store_miss ack: done=%b da_we=%b want 1 0", bus.cpu_done, bus.da_we); end
      @(negedge clk); bus.mem_ack = 0; #1;
      checks++;
      if (bus.hm_valid !== 4'hf) begin errors++; $display("FAIL store_miss valid: got %b want 1111", bus.hm_valid); end
      @(negedge clk);
      load(48'h9040, 1, 2'd3, "rr_after_store");
      load(48'h4050, 1, 2'd0, "rr_wrap");
   endtask
   task automatic test_stall_stray();
      bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 48'h7145;
      @(negedge clk); bus.cpu_req = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         checks++;
         if ({bus.mem_req, bus.mem_we, bus.cpu_done, bus.cpu_ready} !== 4'b1000 || bus.mem_addr !== 48'h7140) begin
            errors++; $display("FAIL stall cyc%0d: req=%b we=%b done=%b ready=%b addr=%h", i, bus.mem_req, bus.mem_we, bus.cpu_done, bus.cpu_ready, bus.mem_addr);
         end
      end
      bus.mem_ack = 1; #1;
      checks++;
      if ({bus.cpu_done, bus.da_way} !== 3'b100) begin errors++; $display("FAIL stall ack: done=%b way=%0d want 1 0", bus.cpu_done, bus.da_way); end
      @(negedge clk); bus.mem_ack = 0;
      @(negedge clk); bus.mem_ack = 1; #1;
      checks++;
      if ({bus.cpu_ready, bus.cpu_done, bus.mem_req, bus.da_we} !== 4'b1000) begin
         errors++; $display("FAIL stray_ack: ready=%b done=%b req=%b da_we=%b want 1 0 0 0", bus.cpu_ready, bus.cpu_done, bus.mem_req, bus.da_we);
      end
      @(negedge clk); bus.mem_ack = 0; #1;
      checks++;
      if ({bus.cpu_ready, bus.cpu_done, bus.mem_req} !== 3'b100) begin
         errors++; $display("FAIL stray_after: ready=%b done=%b req=%b want 1 0 0", bus.cpu_ready, bus.cpu_done, bus.mem_req);
      end
      @(negedge clk);
      load(48'h7140, 0, 2'd0, "stall_line_hit");
   endtask
   task automatic test_flush();
      bus.flush = 1; bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 48'h1040;
      @(negedge clk); bus.flush = 0;
      for (int k = 1; k <= 64; k++) begin
         #1;
         checks++;
         if ({bus.cpu_ready, bus.cpu_done, bus.mem_req} !== {1'b0, k == 64, 1'b0}) begin
            errors++; $display("FAIL flush cyc%0d: ready=%b done=%b req=%b want 0 %b 0", k, bus.cpu_ready, bus.cpu_done, bus.mem_req, k == 64);
         end
         @(negedge clk);
      end
      bus.cpu_req = 0; #1;
      checks++;
      if ({bus.cpu_ready, bus.cpu_done} !== 2'b10) begin errors++; $display("FAIL flush end: ready=%b done=%b want 1 0", bus.cpu_ready, bus.cpu_done); end
      @(negedge clk);
      load(48'h1047, 1, 2'd0, "post_flush_set1");
      load(48'h7140, 1, 2'd0, "post_flush_set5");
   endtask
   task automatic test_reset_mid();
      bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 48'h33c0;
      @(negedge clk); bus.cpu_req = 0;
      @(negedge clk); #1;
      checks++;
      if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL pre_abort req: got %b want 1", bus.mem_req); end
      rst_n = 0; #1;
      checks++;
      if ({bus.mem_req, bus.cpu_done, bus.da_we, bus.cpu_ready} !== 4'b0001 || bus.hm_valid !== 4'd0) begin
         errors++; $display("FAIL abort: req=%b done=%b da_we=%b ready=%b valid=%b want 0 0 0 1 0000", bus.mem_req, bus.cpu_done, bus.da_we, bus.cpu_ready, bus.hm_valid);
      end
      @(negedge clk); rst_n = 1;
      @(negedge clk);
      load(48'h1047, 1, 2'd0, "after_abort_set1");
      load(48'h33c0, 1, 2'd0, "after_abort_same");
      load(48'h33c8, 0, 2'd0, "after_abort_hit");
   endtask
   initial begin
      bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.flush = 0; bus.mem_ack = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      test_reset();
      test_miss_hit();
      test_replacement();
      test_store();
      test_stall_stray();
      test_flush();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/cache_controller.md
# cache_controller

Sequencing controller for the 4-way set-associative cache. It owns the tag and valid-bit storage and the per-set replacement state, and feeds the hit/miss comparator path with the four tag/valid pairs of the indexed set. From the returned per-way match vector it decides hit or miss, runs the line refill handshake to memory and issues write-through stores. It sits between the CPU load/store port, the data array and the external memory port.

## Interface
- SETS, 64, number of sets (power of 2); INDEX_W = log2(SETS)
- TAG_W, 36, tag width
- OFF_W, 6, line offset width; address width ADDR_W = TAG_W + INDEX_W + OFF_W (48 by default)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU request valid
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  request address
- cpu_ready  out  1  controller can accept a request (IDLE only)
- cpu_done  out  1  one-cycle pulse, request completed
- flush  in  1  invalidate all lines; sampled in IDLE only
- hm_tag_addr  out  TAG_W  tag of the latched request, to the comparator path
- hm_tag  out  4×TAG_W  stored tags of the indexed set, way 0..3
- hm_valid  out  4  valid bits of the indexed set
- hm_way_hit  in  4  per-way (tag match AND valid), from the comparator path
- hm_hit  in  1  OR of hm_way_hit
- da_we  out  1  data array write strobe
- da_fill  out  1  1 = write the refill line, 0 = write CPU store data
- da_way  out  2  data array way select (read or write)
- da_index  out  INDEX_W  data array set select
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write-through store, 0 = line read
- mem_addr  out  ADDR_W  line-aligned on reads (offset zeroed), full address on writes
- mem_ack  in  1  memory completion, one-cycle pulse

## Operation
- States: IDLE, LOOKUP, REFILL, STORE, FLUSH.
- IDLE: cpu_ready=1.
  - flush=1 takes priority over cpu_req and goes to FLUSH.
  - Otherwise cpu_req=1 latches cpu_we and cpu_addr and goes to LOOKUP.
- LOOKUP: hm_* is driven from the latched index.
  - Load hit: da_way = index of the hit way, cpu_done=1, go to IDLE.
  - Load miss: choose the victim way, go to REFILL.
  - Store, hit or miss: go to STORE. Store hit additionally asserts da_we=1, da_fill=0, da_way = hit way in this cycle.
- Multiple bits set in hm_way_hit: the lowest-numbered way wins.
- REFILL: mem_req=1, mem_we=0 until mem_ack. In the mem_ack cycle:
  - write the tag and set valid for the victim way;
  - da_we=1, da_fill=1, da_way = victim;
  - advance the set's round-robin pointer if the victim was chosen by pointer;
  - cpu_done=1, go to IDLE.
- STORE: write-through with no write-allocate. mem_req=1, mem_we=1 until mem_ack; on mem_ack, cpu_done=1 and go to IDLE. A store miss changes no tag or valid state.
- Victim selection: lowest-numbered invalid way. If all four ways are valid, use the set's 2-bit round-robin pointer, which wraps 3→0.
- FLUSH: a counter sweeps sets 0..SETS-1, one set per cycle, clearing all 4 valid bits of that set. After set SETS-1: cpu_done=1, go to IDLE. Round-robin pointers are not cleared. cpu_req is ignored during FLUSH.

## Timing
- Reset values:
  - state IDLE;
  - all valid bits 0, all round-robin pointers 0, flush counter 0;
  - cpu_ready=1;
  - cpu_done, da_we, da_fill, mem_req and mem_we all 0;
  - mem_addr, da_way and da_index 0.
  - Tag storage is not reset.
- Load hit: request accepted in cycle N, cpu_done in N+1.
- Miss and store: mem_req rises in N+2 (first REFILL/STORE cycle). cpu_done is asserted in the mem_ack cycle.
- Flush: accepted in N, cpu_done in N+SETS.
- mem_addr and mem_we are stable while mem_req=1.
- mem_ack outside REFILL/STORE is ignored.
- Reset asserted mid-operation aborts immediately: mem_req drops, nothing is written, and no cpu_done is produced.
- A tag/valid update in the REFILL ack cycle is visible to a LOOKUP two cycles later.

## Structure
- Package cache_pkg holds:
  - TAG_W, WAYS=4 and default SETS/OFF_W;
  - the state enum type;
  - a packed tag-set typedef (4×TAG_W).
- Sub-module cache_replace: per-set round-robin pointer array plus the invalid-first victim pick. Inputs are the valid vector, index and advance strobe; output is the 2-bit victim.
- Comparator path: instantiated outside, connected through hm_*.

## Test plan
- Reset, then load of 0x0000_0000_1040 (index 1) → miss. mem_req with mem_addr=0x...1040, mem_we=0. Ack → da_we=1, da_fill=1, da_way=0, cpu_done. Repeat the load → cpu_done at N+1, no mem_req.
- Five loads with distinct tags to set 1 → victims 0,1,2,3 (invalid-first), then the fifth evicts way 0 (pointer 0→1). A sixth new tag evicts way 1.
- Store hit to a resident line → da_we=1, da_fill=0 with the correct way, then mem_we=1 until ack, then cpu_done. Store miss → mem write only, and hm_valid of that set is unchanged.
- Flush with SETS=64 → cpu_ready=0 for 64 cycles and cpu_done at N+64. Afterwards, every previously resident address misses.
- mem_req held for 10 cycles with no mem_ack; a stray mem_ack while in IDLE → no state change.
- rst_n low during REFILL → mem_req=0 and all valids 0. The next load of the same address misses.
